// File: rtl/led_counter_ctrl.sv
// led_counter_ctrl: board-level LED counter controller.
// Tick-enable generator, 2-FF synchronisers for the switches and buttons,
// per-button tick-sampled debouncers and a four-mode counter
// (hold, manual, auto-up, auto-down) with wrap or saturate limits.
// Drives the LED bar plus a mode RGB LED (led4) and a limit RGB LED (led5).
// Optional build macro: LED_CNT_REPEAT_EN adds auto-repeat while a button
// is held in MANUAL mode.
module led_counter_ctrl #(
    parameter int WIDTH      = 4,
    parameter int TICK_DIV   = 50000,
    parameter int DB_SAMPLES = 4,
    parameter int AUTO_TICKS = 50,
    parameter int WRAP       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sw,
    input  logic             add,
    input  logic             sub,
    output logic [WIDTH-1:0] led,
    output logic             led4_r,
    output logic             led4_g,
    output logic             led4_b,
    output logic             led5_r,
    output logic             led5_g,
    output logic             led5_b
);

    localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W  = $clog2(DB_SAMPLES + 1);
    localparam int AT_W  = $clog2(AUTO_TICKS + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_SAMPLES - 1);
    localparam logic [AT_W-1:0]  AT_LAST  = AT_W'(AUTO_TICKS - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        HOLD      = 2'b00,
        MANUAL    = 2'b01,
        AUTO_UP   = 2'b10,
        AUTO_DOWN = 2'b11
    } mode_t;

    // Count stepping with the configured limit behaviour.
    function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
        if (v == CNT_MAX) step_up = (WRAP != 0) ? '0 : CNT_MAX;
        else              step_up = v + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] v);
        if (v == '0) step_dn = (WRAP != 0) ? CNT_MAX : '0;
        else         step_dn = v - 1'b1;
    endfunction

    logic [DIV_W-1:0]        div_q, div_d;
    logic                    tick;
    logic [3:0]              sync1_q, sync2_q;
    logic [1:0]              stable_q, stable_d, stable_prev_q;
    logic [1:0][DB_W-1:0]    dbcnt_q, dbcnt_d;
    logic                    press_add, press_sub;
    mode_t                   mode_q, mode_d, mode_in;
    logic                    pause_q, pause_d;
    logic [AT_W-1:0]         timer_q, timer_d;
    logic [WIDTH-1:0]        count_q, count_d;
`ifdef LED_CNT_REPEAT_EN
    logic [AT_W-1:0]         rpt_q, rpt_d;
`endif

    // Tick divider: wraps at TICK_DIV-1, tick marks the last count.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Divider state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div_q <= '0;
        else      div_q <= div_d;
    end

    // Two-flop synchronisers, bit order {sw[1:0], sub, add}.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {sw, sub, add};
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a level must differ on DB_SAMPLES consecutive ticks to be accepted.
    always_comb begin
        stable_d = stable_q;
        dbcnt_d  = dbcnt_q;
        if (tick) begin
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] != stable_q[b]) begin
                    if (dbcnt_q[b] == DB_LAST) begin
                        stable_d[b] = ~stable_q[b];
                        dbcnt_d[b]  = '0;
                    end else begin
                        dbcnt_d[b] = dbcnt_q[b] + 1'b1;
                    end
                end else begin
                    dbcnt_d[b] = '0;
                end
            end
        end
    end

    // Debounced levels and their one-clk-old copy for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_q      <= '0;
            stable_prev_q <= '0;
            dbcnt_q       <= '0;
        end else begin
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            dbcnt_q       <= dbcnt_d;
        end
    end

    assign press_add = stable_q[0] & ~stable_prev_q[0];
    assign press_sub = stable_q[1] & ~stable_prev_q[1];
    assign mode_in   = mode_t'(sync2_q[3:2]);

    // Counter next state: mode follows the switches, a mode change restarts pause and timer.
    always_comb begin
        mode_d  = mode_in;
        pause_d = pause_q;
        timer_d = timer_q;
        count_d = count_q;
`ifdef LED_CNT_REPEAT_EN
        rpt_d   = '0;
`endif
        case (mode_q)
            HOLD: begin
            end
            MANUAL: begin
                if (press_add && !press_sub)      count_d = step_up(count_q);
                else if (press_sub && !press_add) count_d = step_dn(count_q);
`ifdef LED_CNT_REPEAT_EN
                // Repeat only while exactly one button is held, timed from its press.
                rpt_d = rpt_q;
                if (press_add || press_sub || (stable_q[0] == stable_q[1])) begin
                    rpt_d = '0;
                end else if (tick) begin
                    if (rpt_q == AT_LAST) begin
                        rpt_d   = '0;
                        count_d = stable_q[0] ? step_up(count_q) : step_dn(count_q);
                    end else begin
                        rpt_d = rpt_q + 1'b1;
                    end
                end
`endif
            end
            AUTO_UP, AUTO_DOWN: begin
                if (press_add) pause_d = ~pause_q;
                if (press_sub) begin
                    count_d = '0;
                    timer_d = '0;
                end else if (!pause_q && tick) begin
                    if (timer_q == AT_LAST) begin
                        timer_d = '0;
                        count_d = (mode_q == AUTO_UP) ? step_up(count_q) : step_dn(count_q);
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
        if (mode_in != mode_q) begin
            pause_d = 1'b0;
            timer_d = '0;
        end
    end

    // Counter FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= HOLD;
            pause_q <= 1'b0;
            timer_q <= '0;
            count_q <= '0;
`ifdef LED_CNT_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            mode_q  <= mode_d;
            pause_q <= pause_d;
            timer_q <= timer_d;
            count_q <= count_d;
`ifdef LED_CNT_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign led = count_q;

    // Mode indicator; a paused auto mode shows r+g instead of its own colour.
    always_comb begin
        led4_r = 1'b0;
        led4_g = 1'b0;
        led4_b = 1'b0;
        case (mode_q)
            MANUAL:    led4_g = 1'b1;
            AUTO_UP:   led4_b = 1'b1;
            AUTO_DOWN: led4_r = 1'b1;
            default:   led4_r = 1'b0;
        endcase
        if ((mode_q == AUTO_UP || mode_q == AUTO_DOWN) && pause_q) begin
            led4_r = 1'b1;
            led4_g = 1'b1;
            led4_b = 1'b0;
        end
    end

    // Limit indicator: blue at zero, red at full scale, green in between.
    always_comb begin
        led5_r = 1'b0;
        led5_g = 1'b0;
        led5_b = 1'b0;
        if (count_q == '0)          led5_b = 1'b1;
        else if (count_q == CNT_MAX) led5_r = 1'b1;
        else                        led5_g = 1'b1;
    end

endmodule
